// File: rtl/adf4159_axil_regfile_pkg.sv
// Shared types and constants for the ADF4159 AXI4-Lite control register bank.
package adf4159_regs_pkg;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_t;

  localparam logic [3:0] ADF_REG0_OFF = 4'h0;
  localparam logic [3:0] ADF_REG1_OFF = 4'h4;
  localparam logic [3:0] ADF_REG2_OFF = 4'h8;
  localparam logic [3:0] ADF_REG3_OFF = 4'hC;

  localparam int ADF_NUM_REGS = 4;
  typedef logic [$clog2(ADF_NUM_REGS)-1:0] reg_idx_t;

endpackage

// File: rtl/adf4159_axil_regfile_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the ADF4159 register bank.
interface adf4159_axil_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/adf4159_axil_regfile.sv
// AXI4-Lite register bank feeding the ADF4159 serial writer, with per-register write pulses.
// Build option: define ADF4159_WSTRB_EN to honour wstrb byte enables (otherwise full-word writes).
module adf4159_axil_regfile
  import adf4159_regs_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                       s00_axi_aclk,
  input  logic                       s00_axi_areset,
  adf4159_axil_if.slave              s00_axi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        reg_wr_pulse_o
);

  localparam int IDX_W = ADDR_W - 2;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                awready_q, wready_q, arready_q;
  logic                aw_held_q, w_held_q;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic                bvalid_q, rvalid_q;
  axi_resp_t           bresp_q, rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [NUM_REGS-1:0] pulse_q;

  logic                aw_hs, w_hs, ar_hs, b_hs, commit;
  logic                aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata_c;
  logic [DATA_W/8-1:0] wstrb_c;
  logic [IDX_W-1:0]    widx, ridx;
  logic [NUM_REGS-1:0] wsel, rsel;
  logic                w_in_range, r_in_range;
  logic [DATA_W-1:0]   rd_word;

`ifdef ADF4159_WSTRB_EN
  logic [DATA_W/8-1:0] w_strb_q;
  assign wstrb_c = w_held_q ? w_strb_q : s00_axi.wstrb;
`else
  assign wstrb_c = '1;
`endif

  always_comb begin
    aw_hs   = s00_axi.awvalid && awready_q;
    w_hs    = s00_axi.wvalid && wready_q;
    ar_hs   = s00_axi.arvalid && arready_q;
    b_hs    = bvalid_q && s00_axi.bready;
    waddr   = aw_held_q ? aw_addr_q : s00_axi.awaddr;
    wdata_c = w_held_q ? w_data_q : s00_axi.wdata;
    // AW/W stay held through the B phase so readies remain low until the response is taken.
    commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
    aw_held_n = (aw_held_q || aw_hs) && !b_hs;
    w_held_n  = (w_held_q || w_hs) && !b_hs;
    bvalid_n  = commit || (bvalid_q && !s00_axi.bready);
    rvalid_n  = ar_hs || (rvalid_q && !s00_axi.rready);

    widx    = waddr[ADDR_W-1:2];
    ridx    = s00_axi.araddr[ADDR_W-1:2];
    wsel    = '0;
    rsel    = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(widx) == i) wsel[i] = 1'b1;
      if (int'(ridx) == i) begin
        rsel[i] = 1'b1;
        rd_word = regs_q[i];
      end
    end
    w_in_range = |wsel;
    r_in_range = |rsel;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= AXI_OKAY;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef ADF4159_WSTRB_EN
      w_strb_q  <= '0;
`endif
    end else begin
      awready_q <= !(aw_held_n || bvalid_n);
      wready_q  <= !(w_held_n || bvalid_n);
      arready_q <= !rvalid_n;
      aw_held_q <= aw_held_n;
      w_held_q  <= w_held_n;
      bvalid_q  <= bvalid_n;
      rvalid_q  <= rvalid_n;
      pulse_q   <= commit ? wsel : '0;
      if (aw_hs) aw_addr_q <= s00_axi.awaddr;
      if (w_hs)  w_data_q  <= s00_axi.wdata;
`ifdef ADF4159_WSTRB_EN
      if (w_hs)  w_strb_q  <= s00_axi.wstrb;
`endif
      if (commit) bresp_q <= w_in_range ? AXI_OKAY : AXI_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wsel[i]) begin
          for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb_c[b]) regs_q[i][b*8 +: 8] <= wdata_c[b*8 +: 8];
          end
        end
      end
      // Captured from the pre-edge register values, so a same-edge write is not visible.
      if (ar_hs) begin
        rdata_q <= r_in_range ? rd_word : '0;
        rresp_q <= r_in_range ? AXI_OKAY : AXI_SLVERR;
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign reg_wr_pulse_o  = pulse_q;
  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.arready = arready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rresp   = rresp_q;
  assign s00_axi.rdata   = rdata_q;

  logic unused_ok;
`ifdef ADF4159_WSTRB_EN
  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, waddr[1:0], s00_axi.araddr[1:0]};
`else
  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, waddr[1:0], s00_axi.araddr[1:0],
                       s00_axi.wstrb};
`endif

endmodule

// File: tb/tb_adf4159_axil_regfile.sv
// Directed bench for adf4159_axil_regfile with a reference model and B/R response scoreboards.
module tb_adf4159_axil_regfile;
  import adf4159_regs_pkg::*;

  localparam int AW = 5;
  localparam int NR = 4;
  localparam logic [1:0] RESP_OK = 2'b00;
  localparam logic [1:0] RESP_SE = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adf4159_axil_if #(.ADDR_W(AW), .DATA_W(32)) bus ();
  logic [NR*32-1:0] regs;
  logic [NR-1:0]    pulse;

  adf4159_axil_regfile #(.DATA_W(32), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .s00_axi        (bus),
    .regs_o         (regs),
    .reg_wr_pulse_o (pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [NR];
  int          m_pulse [NR];
  logic [1:0]  b_q [$];
  logic [33:0] r_q [$];

  int pulse_cnt [NR];
  int multi_pulse = 0;
  initial for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
    if ($countones(pulse) > 1) multi_pulse <= multi_pulse + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*32-1:0] model_vec();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = m_regs[i];
    return v;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[AW-1:2]);
    b_q.push_back(idx < NR ? RESP_OK : RESP_SE);
    if (idx < NR) begin
`ifdef ADF4159_WSTRB_EN
      for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
`else
      m_regs[idx] = d;
`endif
      m_pulse[idx]++;
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a);
    int idx;
    idx = int'(a[AW-1:2]);
    r_q.push_back(idx < NR ? {RESP_OK, m_regs[idx]} : {RESP_SE, 32'h0});
  endtask

  task automatic xfer(input bit do_aw, input bit do_w, input bit do_ar,
                      input logic [AW-1:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [AW-1:0] ra);
    bit aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs;
    aw_done = !do_aw; w_done = !do_w; ar_done = !do_ar;
    bus.awaddr = wa; bus.wdata = wd; bus.wstrb = ws; bus.araddr = ra;
    if (do_aw) bus.awvalid = 1'b1;
    if (do_w)  bus.wvalid  = 1'b1;
    if (do_ar) bus.arvalid = 1'b1;
    for (int n = 0; n < 50 && !(aw_done && w_done && ar_done); n++) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      ar_hs = bus.arvalid && bus.arready;
      tick();
      if (aw_hs) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
      if (ar_hs) begin ar_done = 1'b1; bus.arvalid = 1'b0; end
    end
    chk("xfer_handshake", {61'h0, aw_done, w_done, ar_done}, 64'h7);
  endtask

  task automatic wait_valid(input bit is_r);
    for (int n = 0; n < 50; n++) begin
      if ((is_r ? bus.rvalid : bus.bvalid) === 1'b1) break;
      tick();
    end
    chk(is_r ? "r_valid_seen" : "b_valid_seen", is_r ? bus.rvalid : bus.bvalid, 1);
  endtask

  task automatic get_b();
    logic [1:0] exp;
    wait_valid(1'b0);
    exp = b_q.pop_front();
    chk("bresp", bus.bresp, exp);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("b_cleared", bus.bvalid, 0);
  endtask

  task automatic get_r();
    logic [33:0] exp;
    wait_valid(1'b1);
    exp = r_q.pop_front();
    chk("rdata", bus.rdata, exp[31:0]);
    chk("rresp", bus.rresp, exp[33:32]);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("r_cleared", bus.rvalid, 0);
  endtask

  logic [3:0]  offs [4];
  logic [31:0] old;

  initial begin
    offs[0] = ADF_REG0_OFF; offs[1] = ADF_REG1_OFF;
    offs[2] = ADF_REG2_OFF; offs[3] = ADF_REG3_OFF;
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pulse[i] = 0; end
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0;
    bus.rready = 0;

    // reset state
    tick(); tick();
    chk("rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
    chk("rst_valids", {bus.bvalid, bus.rvalid}, 0);
    chk("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 0);
    chk("rst_regs", regs, 0);
    chk("rst_pulse", pulse, 0);
    rst = 1'b0;
    tick();
    chk("readies_after_rst", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // 1: write then read back all registers
    for (int i = 0; i < NR; i++) begin
      model_write({1'b0, offs[i]}, 32'(i + 1), 4'hF);
      xfer(1, 1, 0, {1'b0, offs[i]}, 32'(i + 1), 4'hF, '0);
      get_b();
    end
    for (int i = 0; i < NR; i++) begin
      model_read({1'b0, offs[i]});
      xfer(0, 0, 1, '0, '0, '0, {1'b0, offs[i]});
      get_r();
    end
    for (int i = 0; i < NR; i++) chk("t1_pulse_cnt", 64'(pulse_cnt[i]), 64'(m_pulse[i]));

    // 2: W three cycles ahead of AW
    model_write(5'h08, 32'hDEADBEEF, 4'hF);
    xfer(0, 1, 0, '0, 32'hDEADBEEF, 4'hF, '0);
    for (int n = 0; n < 3; n++) begin
      chk("t2_no_early_b", bus.bvalid, 0);
      tick();
    end
    xfer(1, 0, 0, 5'h08, 32'h0, 4'h0, '0);
    chk("t2_bvalid_latency", bus.bvalid, 1);
    get_b();
    chk("t2_reg2", regs[95:64], 32'hDEADBEEF);

    // 3: B back-pressure stalls a second write
    model_write(5'h00, 32'hCAFE0001, 4'hF);
    xfer(1, 1, 0, 5'h00, 32'hCAFE0001, 4'hF, '0);
    wait_valid(1'b0);
    bus.awaddr = 5'h00; bus.awvalid = 1'b1; bus.wdata = 32'h0000BEEF; bus.wvalid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t3_stall_state", {bus.bvalid, bus.bresp, bus.awready, bus.wready}, 5'b10000);
      chk("t3_reg0_held", regs[31:0], 32'hCAFE0001);
    end
    get_b();
    model_write(5'h00, 32'h0000BEEF, 4'hF);
    xfer(1, 1, 0, 5'h00, 32'h0000BEEF, 4'hF, '0);
    get_b();
    chk("t3_reg0", regs[31:0], m_regs[0]);

    // 4: same-edge read and write of reg1, read held under rready low
    old = m_regs[1];
    model_read(5'h04);
    model_write(5'h04, 32'h55, 4'hF);
    xfer(1, 1, 1, 5'h04, 32'h55, 4'hF, 5'h04);
    for (int n = 0; n < 4; n++) begin
      chk("t4_rvalid_hold", bus.rvalid, 1);
      chk("t4_rdata_old", bus.rdata, old);
      tick();
    end
    get_r();
    get_b();
    model_read(5'h04);
    xfer(0, 0, 1, '0, '0, '0, 5'h04);
    get_r();

    // 5: out-of-range write and read, misaligned read
    model_write(5'h10, 32'h12345678, 4'hF);
    xfer(1, 1, 0, 5'h10, 32'h12345678, 4'hF, '0);
    get_b();
    chk("t5_regs_unchanged", regs, model_vec());
    for (int i = 0; i < NR; i++) chk("t5_pulse_cnt", 64'(pulse_cnt[i]), 64'(m_pulse[i]));
    model_read(5'h10);
    xfer(0, 0, 1, '0, '0, '0, 5'h10);
    get_r();
    model_read(5'h1C);
    xfer(0, 0, 1, '0, '0, '0, 5'h1C);
    get_r();
    model_read(5'h06);
    xfer(0, 0, 1, '0, '0, '0, 5'h06);
    get_r();

    // 6: byte strobes
    model_write(5'h00, 32'h11223344, 4'hF);
    xfer(1, 1, 0, 5'h00, 32'h11223344, 4'hF, '0);
    get_b();
    model_write(5'h00, 32'hAABBCCDD, 4'b0101);
    xfer(1, 1, 0, 5'h00, 32'hAABBCCDD, 4'b0101, '0);
    get_b();
`ifdef ADF4159_WSTRB_EN
    chk("t6_strobe_reg0", regs[31:0], 32'h11BB33DD);
`else
    chk("t6_strobe_reg0", regs[31:0], 32'hAABBCCDD);
`endif
    model_read(5'h00);
    xfer(0, 0, 1, '0, '0, '0, 5'h00);
    get_r();

    // reset in the middle of a write
    xfer(1, 0, 0, 5'h0C, 32'h0, 4'hF, '0);
    rst = 1'b1;
    tick();
    chk("mid_rst_state", {bus.bvalid, bus.awready, bus.wready, bus.arready}, 0);
    chk("mid_rst_regs", regs, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    xfer(0, 1, 0, '0, 32'h77, 4'hF, '0);
    for (int n = 0; n < 3; n++) begin
      chk("mid_rst_no_b", bus.bvalid, 0);
      tick();
    end
    for (int i = 0; i < NR; i++) begin
      model_read({1'b0, offs[i]});
      xfer(0, 0, 1, '0, '0, '0, {1'b0, offs[i]});
      get_r();
    end
    chk("post_rst_regs", regs, model_vec());
    for (int i = 0; i < NR; i++) chk("final_pulse_cnt", 64'(pulse_cnt[i]), 64'(m_pulse[i]));
    chk("pulse_one_hot", 64'(multi_pulse), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
